// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the triggered ADC capture controller.
package adc_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_ARMED      = 3'd2,
        ST_CAPTURE    = 3'd3,
        ST_READOUT    = 3'd4
    } state_t;

    localparam logic TRIG_RISING  = 1'b0;
    localparam logic TRIG_FALLING = 1'b1;

    localparam int DEFAULT_CAPTURE_DEPTH = 256;

endpackage

// File: rtl/capture_buffer_ram.sv
// Simple dual-port capture store: one synchronous write port, one synchronous
// read port. The array has no reset; only the read register does, so the
// readout data path comes up at zero.
module capture_buffer_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; re-reading the same address holds the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered capture controller: enables the sampler, aligns to a frame start,
// waits for a threshold crossing or forced trigger, stores CAPTURE_DEPTH
// samples and plays them back over a valid/ready port.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | sampler off, waiting for arm
// ST_WAIT_FRAME | sampler on, discarding samples until a frame start
// ST_ARMED      | comparing consecutive samples against threshold
// ST_CAPTURE    | writing samples to addresses 1..CAPTURE_DEPTH-1
// ST_READOUT    | sampler off, one prefetch cycle then valid/ready playback
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int CAPTURE_DEPTH = DEFAULT_CAPTURE_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  force_trig,
    input  logic [DATA_WIDTH-1:0] threshold,
    input  logic                  trig_falling,
    output logic                  sampler_enable,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_frame_start,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done
);

    localparam int AW = $clog2(CAPTURE_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(CAPTURE_DEPTH - 1);
    localparam logic [AW-1:0] ONE_ADDR  = AW'(1);

    state_t                r_state;
    logic                  r_force_pend;
    logic [DATA_WIDTH-1:0] r_prev;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic                  r_sampler_enable;
    logic                  r_rd_valid;
    logic                  r_rd_last;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_rise;
    logic                  w_fall;
    logic                  w_cross;
    logic                  w_trig;
    logic                  w_we;
    logic                  w_hs;
    logic [AW-1:0]         w_wr_ptr_nxt;
    logic [AW-1:0]         w_rd_ptr_nxt;
    logic [AW-1:0]         w_raddr;

    assign w_rise  = (r_prev < threshold) && (s_data >= threshold);
    assign w_fall  = (r_prev > threshold) && (s_data <= threshold);
    assign w_cross = (trig_falling == TRIG_RISING) ? w_rise : w_fall;
    assign w_trig  = (r_state == ST_ARMED) && s_valid && (r_force_pend || w_cross);

    // In ARMED the write pointer is still 0, so the trigger sample lands at address 0.
    assign w_we = !abort && (w_trig || ((r_state == ST_CAPTURE) && s_valid));

    assign w_hs         = r_rd_valid && rd_ready;
    assign w_wr_ptr_nxt = r_wr_ptr + ONE_ADDR;
    assign w_rd_ptr_nxt = r_rd_ptr + ONE_ADDR;
    assign w_raddr      = w_hs ? w_rd_ptr_nxt : r_rd_ptr;

    capture_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (CAPTURE_DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (s_data),
        .i_raddr (w_raddr),
        .o_rdata (rd_data)
    );

    // Capture sequencing FSM with registered outputs; abort overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_force_pend     <= 1'b0;
            r_prev           <= '0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_sampler_enable <= 1'b0;
            r_rd_valid       <= 1'b0;
            r_rd_last        <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state          <= ST_IDLE;
                r_force_pend     <= 1'b0;
                r_wr_ptr         <= '0;
                r_rd_ptr         <= '0;
                r_sampler_enable <= 1'b0;
                r_rd_valid       <= 1'b0;
                r_rd_last        <= 1'b0;
                r_busy           <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (arm) begin
                            r_state          <= ST_WAIT_FRAME;
                            r_sampler_enable <= 1'b1;
                            r_busy           <= 1'b1;
                        end
                    end
                    ST_WAIT_FRAME: begin
                        if (s_valid && s_frame_start) begin
                            r_prev  <= s_data;
                            r_state <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (force_trig) begin
                            r_force_pend <= 1'b1;
                        end
                        if (s_valid) begin
                            r_prev <= s_data;
                            if (r_force_pend || w_cross) begin
                                r_force_pend <= 1'b0;
                                r_wr_ptr     <= w_wr_ptr_nxt;
                                r_state      <= ST_CAPTURE;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        if (s_valid) begin
                            r_wr_ptr <= w_wr_ptr_nxt;
                            if (r_wr_ptr == LAST_ADDR) begin
                                r_state          <= ST_READOUT;
                                r_sampler_enable <= 1'b0;
                            end
                        end
                    end
                    ST_READOUT: begin
                        if (!r_rd_valid) begin
                            // Prefetch cycle: address 0 is being read this edge.
                            r_rd_valid <= 1'b1;
                            r_rd_last  <= 1'b0;
                        end else if (w_hs) begin
                            if (r_rd_last) begin
                                r_state    <= ST_IDLE;
                                r_rd_valid <= 1'b0;
                                r_rd_last  <= 1'b0;
                                r_rd_ptr   <= '0;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                            end else begin
                                r_rd_ptr  <= w_rd_ptr_nxt;
                                r_rd_last <= (w_rd_ptr_nxt == LAST_ADDR);
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sampler_enable = r_sampler_enable;
    assign rd_valid       = r_rd_valid;
    assign rd_last        = r_rd_last;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: stimulus pushes expected readout
// words, a negedge monitor pops and compares on each read handshake.
module tb_adc_capture_ctrl;
    import adc_capture_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          force_trig = 1'b0;
    logic [DW-1:0] threshold = '0;
    logic          trig_falling = 1'b0;
    logic          sampler_enable;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_frame_start = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready = 1'b1;
    logic          rd_last;
    logic          busy;
    logic          done;

    adc_capture_ctrl #(.DATA_WIDTH(DW), .CAPTURE_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .arm            (arm),
        .abort          (abort),
        .force_trig     (force_trig),
        .threshold      (threshold),
        .trig_falling   (trig_falling),
        .sampler_enable (sampler_enable),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_frame_start  (s_frame_start),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_last        (rd_last),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   hs_count = 0;
    logic bp_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [DW-1:0] d, input int i);
        exp_t e;
        e.data = d;
        e.last = (i == DEPTH - 1);
        return e;
    endfunction

    function automatic logic [DW-1:0] fill(input int k);
        logic [DW-1:0] kk;
        kk = k[DW-1:0];
        return kk ^ 8'hA5;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic fs);
        tick();
        s_data        = d;
        s_valid       = 1'b1;
        s_frame_start = fs;
    endtask

    task automatic quiet();
        tick();
        s_valid       = 1'b0;
        s_frame_start = 1'b0;
    endtask

    task automatic do_arm(input string name);
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk({name, "_arm_en"}, sampler_enable, 1);
        chk({name, "_arm_busy"}, busy, 1);
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 3000 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({name, "_done_seen"}, seen, 1);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        tick();
    endtask

    // Read-side ready driver: always ready, or a 1,0,0,1 pattern under backpressure.
    initial begin
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                rd_ready = pat[k % 4];
                k++;
            end else begin
                rd_ready = 1'b1;
            end
        end
    end

    // Monitor: compares each handshake against the scoreboard, checks stall hold and done.
    initial begin
        logic          held_v;
        logic [DW-1:0] held_d;
        logic          last_hs;
        exp_t          e;
        held_v  = 1'b0;
        held_d  = '0;
        last_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v  = 1'b0;
                last_hs = 1'b0;
            end else begin
                chk("done_pulse", done, last_hs);
                if (last_hs) chk("busy_at_done", busy, 0);
                last_hs = 1'b0;
                if (rd_valid && held_v) chk("stall_hold", rd_data, held_d);
                held_v = 1'b0;
                if (rd_valid) begin
                    if (rd_ready) begin
                        hs_count++;
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)", rd_data, $time);
                        end else begin
                            e = exp_q.pop_front();
                            chk("rd_data", rd_data, e.data);
                            chk("rd_last", rd_last, e.last);
                            last_hs = e.last;
                        end
                    end else begin
                        held_v = 1'b1;
                        held_d = rd_data;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;

        // Reset values
        #1;
        chk("rst_en", sampler_enable, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Rising trigger on a ramp through 0x80
        threshold = 8'h80;
        trig_falling = TRIG_RISING;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(mk(8'(8'h80 + i), i));
        do_arm("rise");
        send(8'h7F, 1'b0);
        send(8'h85, 1'b0);
        for (int i = 0; i < 272; i++) send(8'(8'h70 + i), i == 0);
        quiet();
        chk("rise_en_drop", sampler_enable, 0);
        chk("rise_busy_readout", busy, 1);
        chk("rise_prefetch", rd_valid, 0);
        wait_done("rise");
        chk("rise_idle_busy", busy, 0);

        // Falling trigger: 0x50, 0x45, 0x40, 0x30
        threshold = 8'h40;
        trig_falling = TRIG_FALLING;
        exp_q.push_back(mk(8'h40, 0));
        exp_q.push_back(mk(8'h30, 1));
        for (int i = 2; i < DEPTH; i++) exp_q.push_back(mk(fill(i), i));
        do_arm("fall");
        send(8'h50, 1'b1);
        send(8'h45, 1'b0);
        send(8'h40, 1'b0);
        send(8'h30, 1'b0);
        for (int i = 2; i < DEPTH; i++) send(fill(i), 1'b0);
        quiet();
        chk("fall_en_drop", sampler_enable, 0);
        wait_done("fall");

        // Force trigger with readout backpressure; a force pulse in IDLE must be forgotten
        threshold = 8'h80;
        trig_falling = TRIG_RISING;
        bp_mode = 1'b1;
        h0 = hs_count;
        tick();
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        chk("force_idle_busy", busy, 0);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(mk(8'h10, i));
        do_arm("force");
        send(8'h10, 1'b1);
        for (int j = 1; j <= 10; j++) send(8'(8'h10 + j), 1'b0);
        tick();
        s_valid = 1'b0;
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(8'h10, 1'b0);
        quiet();
        chk("force_en_drop", sampler_enable, 0);
        wait_done("force");
        chk("bp_handshakes", hs_count - h0, DEPTH);
        bp_mode = 1'b0;

        // Abort after 100 capture writes, then re-arm and capture afresh
        do_arm("abort");
        send(8'h70, 1'b1);
        for (int i = 1; i < 16; i++) send(8'(8'h70 + i), 1'b0);
        for (int i = 0; i < 100; i++) send(8'(8'h80 + i), 1'b0);
        tick();
        abort = 1'b1;
        s_data = 8'hE4;
        s_valid = 1'b1;
        tick();
        abort = 1'b0;
        s_valid = 1'b0;
        chk("abort_en", sampler_enable, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rd_valid", rd_valid, 0);
        chk("abort_done", done, 0);
        tick();
        chk("abort_stay_idle", busy, 0);
        exp_q.push_back(mk(8'h90, 0));
        for (int i = 1; i < DEPTH; i++) exp_q.push_back(mk(fill(i), i));
        do_arm("rearm");
        send(8'h7E, 1'b0);
        send(8'h7F, 1'b0);
        send(8'h80, 1'b0);
        send(8'h81, 1'b0);
        send(8'h20, 1'b1);
        send(8'h30, 1'b0);
        send(8'h90, 1'b0);
        for (int i = 1; i < DEPTH; i++) send(fill(i), 1'b0);
        quiet();
        chk("rearm_en_drop", sampler_enable, 0);
        wait_done("rearm");

        // arm together with abort in IDLE
        tick();
        arm = 1'b1;
        abort = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        chk("armabort_busy", busy, 0);
        chk("armabort_en", sampler_enable, 0);
        tick();
        chk("armabort_busy2", busy, 0);

        // Asynchronous reset in the middle of readout
        threshold = 8'h80;
        trig_falling = TRIG_RISING;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(mk(8'(8'h80 + i), i));
        do_arm("rstmid");
        for (int i = 0; i < 272; i++) send(8'(8'h70 + i), i == 0);
        quiet();
        repeat (40) tick();
        chk("rstmid_readout_active", rd_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_en", sampler_enable, 0);
        chk("rstmid_rd_valid", rd_valid, 0);
        chk("rstmid_rd_last", rd_last, 0);
        chk("rstmid_rd_data", rd_data, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstmid_after_busy", busy, 0);
        chk("rstmid_after_rd_valid", rd_valid, 0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
